// File: rtl/rs_issue_ctrl.sv
// Reservation-station issue/allocate controller: oldest-first select per FU port,
// lowest-index allocation per dispatch slot, and a registered free-entry credit/stall.
module rs_issue_ctrl #(
   parameter int unsigned RS_SIZE        = 16,
   parameter int unsigned ISSUE_WIDTH    = 3,
   parameter int unsigned DISPATCH_WIDTH = 3,
   parameter int unsigned ROB_WIDTH      = 5,
   localparam int unsigned IDX_W         = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1,
   localparam int unsigned CRD_W         = IDX_W + 1,
   localparam int unsigned AGE_W         = ROB_WIDTH + 1
) (
   input  logic                                        clk,
   input  logic                                        rst_n,
   input  logic                                        pipe_flush,
   input  logic [RS_SIZE-1:0][ISSUE_WIDTH-1:0]         rs_wake_up,
   input  logic [RS_SIZE-1:0]                          rs_avail,
   input  logic [RS_SIZE-1:0][AGE_W-1:0]               rs_age,
   input  logic [AGE_W-1:0]                            rob_head,
   input  logic [ISSUE_WIDTH-1:0]                      fu_ready,
   input  logic [DISPATCH_WIDTH-1:0]                   dispatch_req,
   output logic [RS_SIZE-1:0]                          rs_use_en,
   output logic [RS_SIZE-1:0]                          rs_load,
   output logic [DISPATCH_WIDTH-1:0][IDX_W-1:0]        load_idx,
   output logic                                        dispatch_stall,
   output logic [ISSUE_WIDTH-1:0]                      issue_valid,
   output logic [ISSUE_WIDTH-1:0][IDX_W-1:0]           issue_idx,
   output logic [CRD_W-1:0]                            free_credit
);

   logic [ISSUE_WIDTH-1:0][RS_SIZE-1:0] w_grant;
   logic [ISSUE_WIDTH-1:0]              w_gvld;
   logic [ISSUE_WIDTH-1:0][IDX_W-1:0]   w_gidx;
   logic [RS_SIZE-1:0]                  w_taken;
   logic [RS_SIZE-1:0]                  w_claimed;
   logic                                w_alloc_ok;
   logic [CRD_W-1:0]                    w_credit_nxt;
   logic                                w_stall_nxt;

   logic [CRD_W-1:0]                    r_credit;
   logic                                r_stall;
   logic [ISSUE_WIDTH-1:0]              r_issue_vld;
   logic [ISSUE_WIDTH-1:0][IDX_W-1:0]   r_issue_idx;

   // Age is measured relative to rob_head so the wrap bit orders tags correctly;
   // strict '<' keeps the lower index on ties, and w_taken stops double grants.
   always_comb begin
      logic             w_found;
      logic [AGE_W-1:0] w_best;
      logic [AGE_W-1:0] w_rel;
      w_grant = '0;
      w_gvld  = '0;
      w_gidx  = '0;
      w_taken = '0;
      w_found = 1'b0;
      w_best  = '0;
      w_rel   = '0;
      for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
         w_found = 1'b0;
         w_best  = '0;
         for (int unsigned e = 0; e < RS_SIZE; e++) begin
            w_rel = rs_age[e] - rob_head;
            if (rs_wake_up[e][i] && !w_taken[e] && (!w_found || (w_rel < w_best))) begin
               w_found   = 1'b1;
               w_best    = w_rel;
               w_gidx[i] = IDX_W'(e);
            end
         end
         if (w_found && fu_ready[i] && !pipe_flush && rst_n) begin
            w_gvld[i]               = 1'b1;
            w_grant[i][w_gidx[i]]   = 1'b1;
            w_taken[w_gidx[i]]      = 1'b1;
         end else begin
            w_gidx[i] = '0;
         end
      end
   end

   always_comb begin
      rs_use_en = '0;
      for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
         rs_use_en = rs_use_en | w_grant[i];
      end
   end

   assign w_alloc_ok = !r_stall && !pipe_flush && rst_n;

   always_comb begin
      logic w_done;
      w_claimed = '0;
      load_idx  = '0;
      w_done    = 1'b0;
      for (int unsigned d = 0; d < DISPATCH_WIDTH; d++) begin
         w_done = 1'b0;
         if (dispatch_req[d] && w_alloc_ok) begin
            for (int unsigned e = 0; e < RS_SIZE; e++) begin
               if (!w_done && rs_avail[e] && !w_claimed[e]) begin
                  w_done       = 1'b1;
                  w_claimed[e] = 1'b1;
                  load_idx[d]  = IDX_W'(e);
               end
            end
         end
      end
   end

   assign rs_load = w_claimed;

   always_comb begin
      int w_sum;
      w_sum = int'(r_credit) - $countones(rs_load) + $countones(rs_use_en);
      if (w_sum < 0) begin
         w_sum = 0;
      end else if (w_sum > int'(RS_SIZE)) begin
         w_sum = int'(RS_SIZE);
      end
      w_credit_nxt = CRD_W'(w_sum);
      w_stall_nxt  = (w_sum < int'(DISPATCH_WIDTH));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_credit    <= CRD_W'(RS_SIZE);
         r_stall     <= 1'b0;
         r_issue_vld <= '0;
         r_issue_idx <= '0;
      end else if (pipe_flush) begin
         r_credit    <= CRD_W'(RS_SIZE);
         r_stall     <= (RS_SIZE < DISPATCH_WIDTH);
         r_issue_vld <= '0;
         r_issue_idx <= '0;
      end else begin
         r_credit    <= w_credit_nxt;
         r_stall     <= w_stall_nxt;
         r_issue_vld <= w_gvld;
         r_issue_idx <= w_gidx;
      end
   end

   assign free_credit    = r_credit;
   assign dispatch_stall = r_stall;
   assign issue_valid    = r_issue_vld;
   assign issue_idx      = r_issue_idx;

endmodule

// File: tb/tb_rs_issue_ctrl.sv
// Directed bench for rs_issue_ctrl; a small RS occupancy model drives rs_avail
// and ties free_credit to the number of free entries every cycle.
module tb_rs_issue_ctrl;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 pipe_flush;
   logic [15:0][2:0]     rs_wake_up;
   logic [15:0]          rs_avail;
   logic [15:0][5:0]     rs_age;
   logic [5:0]           rob_head;
   logic [2:0]           fu_ready;
   logic [2:0]           dispatch_req;
   logic [15:0]          rs_use_en;
   logic [15:0]          rs_load;
   logic [2:0][3:0]      load_idx;
   logic                 dispatch_stall;
   logic [2:0]           issue_valid;
   logic [2:0][3:0]      issue_idx;
   logic [4:0]           free_credit;

   int                   n_checks = 0;
   int                   n_errors = 0;
   logic [15:0]          avail_m  = '1;

   rs_issue_ctrl #(
      .RS_SIZE        (16),
      .ISSUE_WIDTH    (3),
      .DISPATCH_WIDTH (3),
      .ROB_WIDTH      (5)
   ) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .pipe_flush     (pipe_flush),
      .rs_wake_up     (rs_wake_up),
      .rs_avail       (rs_avail),
      .rs_age         (rs_age),
      .rob_head       (rob_head),
      .fu_ready       (fu_ready),
      .dispatch_req   (dispatch_req),
      .rs_use_en      (rs_use_en),
      .rs_load        (rs_load),
      .load_idx       (load_idx),
      .dispatch_stall (dispatch_stall),
      .issue_valid    (issue_valid),
      .issue_idx      (issue_idx),
      .free_credit    (free_credit)
   );

   always #5 clk = ~clk;

   assign rs_avail = avail_m;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Entries leave the free pool on allocation and return on issue or flush.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)          avail_m <= '1;
      else if (pipe_flush) avail_m <= '1;
      else                 avail_m <= (avail_m & ~rs_load) | rs_use_en;
   end

   always @(negedge clk) begin
      if (rst_n) check_eq("credit_vs_avail", 32'(free_credit), 32'($countones(avail_m)));
   end

   task automatic clear_wake();
      rs_wake_up = '0;
   endtask

   initial begin
      rst_n        = 1'b1;
      pipe_flush   = 1'b0;
      rs_wake_up   = '0;
      rs_age       = '0;
      rob_head     = '0;
      fu_ready     = 3'b000;
      dispatch_req = 3'b111;
      #1 rst_n = 1'b0;
      #2;
      check_eq("rst_credit",   32'(free_credit),    32'd16);
      check_eq("rst_stall",    32'(dispatch_stall), 32'd0);
      check_eq("rst_ivalid",   32'(issue_valid),    32'd0);
      check_eq("rst_iidx",     32'(issue_idx),      32'd0);
      check_eq("rst_load",     32'(rs_load),        32'd0);
      check_eq("rst_use",      32'(rs_use_en),      32'd0);

      @(negedge clk);
      @(negedge clk);
      rst_n        = 1'b1;
      fu_ready     = 3'b111;
      dispatch_req = 3'b101;
      #1;
      check_eq("alloc101_load", 32'(rs_load),     32'h0003);
      check_eq("alloc101_idx0", 32'(load_idx[0]), 32'd0);
      check_eq("alloc101_idx1", 32'(load_idx[1]), 32'd0);
      check_eq("alloc101_idx2", 32'(load_idx[2]), 32'd1);
      @(posedge clk); #1;
      check_eq("alloc101_credit", 32'(free_credit),    32'd14);
      check_eq("alloc101_stall",  32'(dispatch_stall), 32'd0);

      @(negedge clk);
      dispatch_req = 3'b000;
      pipe_flush   = 1'b1;
      @(posedge clk); #1;
      check_eq("flush_idle_credit", 32'(free_credit), 32'd16);
      @(negedge clk);
      pipe_flush = 1'b0;

      for (int c = 0; c < 5; c++) begin
         dispatch_req = 3'b111;
         #1;
         check_eq("fill_load", 32'(rs_load), 32'(16'h0007 << (3 * c)));
         @(posedge clk); #1;
         check_eq("fill_credit", 32'(free_credit), 32'(16 - 3 * (c + 1)));
         check_eq("fill_stall",  32'(dispatch_stall), (c == 4) ? 32'd1 : 32'd0);
         @(negedge clk);
      end

      rob_head      = 6'd30;
      rs_age[2]     = 6'd31;
      rs_age[7]     = 6'd1;
      rs_wake_up[2] = 3'b001;
      rs_wake_up[7] = 3'b001;
      #1;
      check_eq("stalled_load", 32'(rs_load),   32'd0);
      check_eq("age_use",      32'(rs_use_en), 32'h0004);
      @(posedge clk); #1;
      check_eq("age_credit", 32'(free_credit),    32'd2);
      check_eq("age_stall",  32'(dispatch_stall), 32'd1);
      check_eq("age_ivalid", 32'(issue_valid),    32'b001);
      check_eq("age_iidx0",  32'(issue_idx[0]),   32'd2);

      @(negedge clk);
      clear_wake();
      dispatch_req  = 3'b000;
      rob_head      = 6'd62;
      rs_age[5]     = 6'd63;
      rs_age[6]     = 6'd0;
      rs_wake_up[5] = 3'b001;
      rs_wake_up[6] = 3'b001;
      #1;
      check_eq("wrap_use", 32'(rs_use_en), 32'h0020);
      @(posedge clk); #1;
      check_eq("wrap_credit", 32'(free_credit),    32'd3);
      check_eq("wrap_stall",  32'(dispatch_stall), 32'd0);
      check_eq("wrap_iidx0",  32'(issue_idx[0]),   32'd5);

      @(negedge clk);
      clear_wake();
      fu_ready      = 3'b101;
      rs_age[4]     = 6'd10;
      rs_age[9]     = 6'd10;
      rs_wake_up[4] = 3'b100;
      rs_wake_up[9] = 3'b100;
      rs_wake_up[6] = 3'b010;
      #1;
      check_eq("tie_bp_use", 32'(rs_use_en), 32'h0010);
      @(posedge clk); #1;
      check_eq("tie_credit", 32'(free_credit),  32'd4);
      check_eq("tie_ivalid", 32'(issue_valid),  32'b100);
      check_eq("tie_iidx2",  32'(issue_idx[2]), 32'd4);
      check_eq("bp_iidx1",   32'(issue_idx[1]), 32'd0);

      @(negedge clk);
      rs_wake_up[4] = 3'b000;
      fu_ready      = 3'b111;
      #1;
      check_eq("bp_release_use", 32'(rs_use_en), 32'h0240);
      @(posedge clk); #1;
      check_eq("bp_credit", 32'(free_credit),  32'd6);
      check_eq("bp_ivalid", 32'(issue_valid),  32'b110);
      check_eq("bp_iidx1b", 32'(issue_idx[1]), 32'd6);
      check_eq("bp_iidx2b", 32'(issue_idx[2]), 32'd9);

      @(negedge clk);
      clear_wake();
      dispatch_req = 3'b111;
      #1;
      check_eq("holes_load", 32'(rs_load),     32'h0034);
      check_eq("holes_idx0", 32'(load_idx[0]), 32'd2);
      check_eq("holes_idx1", 32'(load_idx[1]), 32'd4);
      check_eq("holes_idx2", 32'(load_idx[2]), 32'd5);
      @(posedge clk); #1;
      check_eq("holes_credit", 32'(free_credit),    32'd3);
      check_eq("holes_stall",  32'(dispatch_stall), 32'd0);

      @(negedge clk);
      rs_wake_up[0] = 3'b001;
      pipe_flush    = 1'b1;
      #1;
      check_eq("flush_load", 32'(rs_load),   32'd0);
      check_eq("flush_use",  32'(rs_use_en), 32'd0);
      @(posedge clk); #1;
      check_eq("flush_credit", 32'(free_credit),    32'd16);
      check_eq("flush_stall",  32'(dispatch_stall), 32'd0);
      check_eq("flush_ivalid", 32'(issue_valid),    32'd0);

      @(negedge clk);
      pipe_flush = 1'b0;
      clear_wake();
      dispatch_req = 3'b111;
      #1;
      check_eq("post_flush_load", 32'(rs_load), 32'h0007);
      @(posedge clk); #1;
      check_eq("post_flush_credit", 32'(free_credit), 32'd13);

      @(negedge clk);
      dispatch_req  = 3'b001;
      rs_wake_up[1] = 3'b100;
      #1;
      check_eq("mix_load", 32'(rs_load),   32'h0008);
      check_eq("mix_use",  32'(rs_use_en), 32'h0002);
      @(posedge clk); #1;
      check_eq("mix_credit", 32'(free_credit),  32'd13);
      check_eq("mix_ivalid", 32'(issue_valid),  32'b100);
      check_eq("mix_iidx2",  32'(issue_idx[2]), 32'd1);

      #2 rst_n = 1'b0;
      #1;
      check_eq("midrst_credit", 32'(free_credit),    32'd16);
      check_eq("midrst_stall",  32'(dispatch_stall), 32'd0);
      check_eq("midrst_ivalid", 32'(issue_valid),    32'd0);
      check_eq("midrst_iidx",   32'(issue_idx),      32'd0);
      check_eq("midrst_load",   32'(rs_load),        32'd0);
      check_eq("midrst_use",    32'(rs_use_en),      32'd0);

      @(negedge clk);
      rst_n        = 1'b1;
      clear_wake();
      dispatch_req = 3'b000;
      #1;
      check_eq("idle_load", 32'(rs_load),   32'd0);
      check_eq("idle_use",  32'(rs_use_en), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check_eq("idle_credit", 32'(free_credit), 32'd16);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
